// File: rtl/expu_correction_arbiter.sv
// Round-robin front end for a single shared mantissa correction unit: grants one
// requester per cycle, tracks the unit's register stage and queues tagged results.
module expu_correction_arbiter #(
    parameter int N_REQ          = 4,
    parameter int INPUT_FRACTION = 7,
    parameter int FIFO_DEPTH     = 2,
    localparam int ID_WIDTH      = $clog2(N_REQ)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic [N_REQ-1:0]                  req_valid_i,
    input  logic [N_REQ*INPUT_FRACTION-1:0]   req_mant_i,
    output logic [N_REQ-1:0]                  req_ready_o,
    output logic                              corr_enable_o,
    output logic                              corr_clear_o,
    output logic [INPUT_FRACTION-1:0]         corr_mantissa_o,
    input  logic [INPUT_FRACTION-1:0]         corr_result_i,
    output logic                              res_valid_o,
    input  logic                              res_ready_i,
    output logic [INPUT_FRACTION-1:0]         res_mant_o,
    output logic [ID_WIDTH-1:0]               res_id_o,
    output logic                              idle_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Handshake: a requester transfers in any cycle where req_valid_i[k] and
    // req_ready_o[k] are both high; the result side transfers on res_valid_o & res_ready_i.

    logic                      slot_valid_q;
    logic [ID_WIDTH-1:0]       slot_id_q;
    logic [ID_WIDTH-1:0]       last_q;
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [CNT_W-1:0]          count_q;
    logic [INPUT_FRACTION-1:0] mant_q [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]       id_q   [FIFO_DEPTH];

    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      issue_ok;
    logic                      grant;
    logic                      found;
    logic [ID_WIDTH-1:0]       winner;
    logic [ID_WIDTH-1:0]       cand;
    logic [CNT_W:0]            occ;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign res_valid_o  = (count_q != '0);
    assign res_mant_o   = mant_q[rd_ptr_q];
    assign res_id_o     = id_q[rd_ptr_q];
    assign idle_o       = ~slot_valid_q & (count_q == '0);
    assign corr_clear_o = clear_i;

    assign push = slot_valid_q;
    assign pop  = res_valid_o & res_ready_i;
    assign full = (count_q == CNT_W'(FIFO_DEPTH));

    // Entries already committed (buffered + in the unit's register) minus the one
    // leaving this cycle must leave room for the result a new grant will produce.
    assign occ      = {1'b0, count_q} + {{CNT_W{1'b0}}, slot_valid_q} - {{CNT_W{1'b0}}, pop};
    assign issue_ok = rst_ni & ~clear_i & (occ < (CNT_W + 1)'(FIFO_DEPTH));

    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_WIDTH'((int'(last_q) + i) % N_REQ);
            if (!found && req_valid_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign grant = issue_ok & found;

    always_comb begin
        req_ready_o     = '0;
        corr_enable_o   = 1'b0;
        corr_mantissa_o = '0;
        if (grant) begin
            req_ready_o[winner] = 1'b1;
            corr_enable_o       = 1'b1;
            corr_mantissa_o     = req_mant_i[winner*INPUT_FRACTION +: INPUT_FRACTION];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= 1'b0;
            slot_id_q    <= '0;
            last_q       <= ID_WIDTH'(N_REQ - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mant_q[i] <= '0;
                id_q[i]   <= '0;
            end
        end else if (clear_i) begin
            slot_valid_q <= 1'b0;
            last_q       <= ID_WIDTH'(N_REQ - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            slot_valid_q <= grant;
            if (grant) begin
                slot_id_q <= winner;
                last_q    <= winner;
            end
            if (push) begin
                mant_q[wr_ptr_q] <= corr_result_i;
                id_q[wr_ptr_q]   <= slot_id_q;
                wr_ptr_q         <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full && !pop && !clear_i));

    a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_ready_o));

endmodule

// File: tb/tb_expu_correction_arbiter.sv
// Directed + randomized bench for expu_correction_arbiter: a queue-based model
// predicts grants and tagged results; a stand-in correction unit closes the loop.
module tb_expu_correction_arbiter;

    localparam int N = 4;
    localparam int W = 7;
    localparam int D = 2;
    localparam int IW = $clog2(N);

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic clear_i = 1'b0;
    logic res_ready_i = 1'b0;
    logic [N-1:0]   req_valid_i = '0;
    logic [N*W-1:0] req_mant_i = '0;

    logic [N-1:0] rdy0, rdy1;
    logic         en0, en1, cclr0, cclr1, rv0, rv1, idle0, idle1;
    logic [W-1:0] cmant0, cmant1, cres0, cres1, rm0, rm1;
    logic [IW-1:0] rid0, rid1;
    logic [W-1:0] cu0_q, cu1_q;

    always #5 clk_i = ~clk_i;

    // Stand-in correction: normalise by one place when the leading bit is clear.
    function automatic logic [W-1:0] corr_f(input logic [W-1:0] m);
        return m[W-1] ? m : ((m << 1) | W'(1));
    endfunction

    expu_correction_arbiter #(.N_REQ(N), .INPUT_FRACTION(W), .FIFO_DEPTH(D)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .req_valid_i(req_valid_i), .req_mant_i(req_mant_i), .req_ready_o(rdy0),
        .corr_enable_o(en0), .corr_clear_o(cclr0), .corr_mantissa_o(cmant0),
        .corr_result_i(cres0), .res_valid_o(rv0), .res_ready_i(res_ready_i),
        .res_mant_o(rm0), .res_id_o(rid0), .idle_o(idle0));

    expu_correction_arbiter #(.N_REQ(N), .INPUT_FRACTION(W), .FIFO_DEPTH(1)) u_dut_d1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .req_valid_i(req_valid_i), .req_mant_i(req_mant_i), .req_ready_o(rdy1),
        .corr_enable_o(en1), .corr_clear_o(cclr1), .corr_mantissa_o(cmant1),
        .corr_result_i(cres1), .res_valid_o(rv1), .res_ready_i(res_ready_i),
        .res_mant_o(rm1), .res_id_o(rid1), .idle_o(idle1));

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      cu0_q <= '0;
        else if (cclr0)   cu0_q <= '0;
        else if (en0)     cu0_q <= cmant0;
    end
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      cu1_q <= '0;
        else if (cclr1)   cu1_q <= '0;
        else if (en1)     cu1_q <= cmant1;
    end
    assign cres0 = corr_f(cu0_q);
    assign cres1 = corr_f(cu1_q);

    typedef struct {
        int           id;
        logic [W-1:0] m;
        int           rdy;
    } ent_t;

    ent_t         exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           g_last = N - 1;
    int           last_grant = -1;
    int           grants;
    logic [N-1:0] req_v = '0;
    logic [W-1:0] req_m [N];
    logic         rr = 1'b0;
    logic         clr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, predict from the model, compare, then advance the model.
    task automatic step();
        logic         vis, pop, issue, grant;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] exp_m;
        int           w, occ;
        @(negedge clk_i);
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]       = req_v[k];
            req_mant_i[k*W +: W] = req_m[k];
        end
        res_ready_i = rr;
        clear_i     = clr;
        #1;
        vis   = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
        pop   = vis && rr;
        occ   = exp_q.size() - (pop ? 1 : 0);
        issue = !clr && (occ < D);
        w = -1;
        for (int i = 1; i <= N; i++)
            if (w < 0 && req_v[(g_last + i) % N]) w = (g_last + i) % N;
        grant   = issue && (w >= 0);
        exp_rdy = '0;
        exp_m   = '0;
        if (grant) begin
            exp_rdy[w] = 1'b1;
            exp_m      = req_m[w];
        end
        check("req_ready", rdy0, exp_rdy);
        check("corr_enable", en0, grant);
        check("corr_mantissa", cmant0, exp_m);
        check("corr_clear", cclr0, clr);
        check("res_valid", rv0, vis);
        if (vis) begin
            check("res_id", rid0, exp_q[0].id);
            check("res_mant", rm0, exp_q[0].m);
        end
        check("idle", idle0, exp_q.size() == 0);
        if (clr) begin
            exp_q.delete();
            g_last = N - 1;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (grant) begin
                exp_q.push_back('{w, corr_f(req_m[w]), cyc + 2});
                g_last = w;
            end
        end
        last_grant = grant ? w : -1;
        cyc++;
    endtask

    // mode 0: granted requester drops; 1: all stay valid; 2: random arrivals.
    task automatic refill(input int mode);
        if (last_grant >= 0) begin
            req_m[last_grant] = W'($urandom);
            if (mode == 0) req_v[last_grant] = 1'b0;
            if (mode == 2) req_v[last_grant] = 1'($urandom_range(0, 1));
        end
        if (mode == 2)
            for (int k = 0; k < N; k++)
                if (!req_v[k] && $urandom_range(0, 3) == 0) begin
                    req_v[k] = 1'b1;
                    req_m[k] = W'($urandom);
                end
    endtask

    task automatic all_valid();
        for (int k = 0; k < N; k++) begin
            req_v[k] = 1'b1;
            req_m[k] = W'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, rdy0, 0);
        check({tag, "_corr_enable"}, en0, 0);
        check({tag, "_corr_mantissa"}, cmant0, 0);
        check({tag, "_res_valid"}, rv0, 0);
        check({tag, "_res_mant"}, rm0, 0);
        check({tag, "_res_id"}, rid0, 0);
        check({tag, "_idle"}, idle0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) req_m[k] = '0;
        #1;
        check_reset_outputs("reset");
        check("reset_corr_clear_lo", cclr0, 0);
        clear_i = 1'b1;
        #1;
        check("reset_corr_clear_hi", cclr0, 1);
        clear_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single request from requester 2.
        rr = 1'b1;
        req_v[2] = 1'b1;
        req_m[2] = 7'h40;
        step();
        check("single_grant", last_grant, 2);
        refill(0);
        step();
        step();
        check("single_res_valid", rv0, 1);
        check("single_res_id", rid0, 2);
        check("single_res_mant", rm0, 7'h40);  // leading bit set: passes unchanged
        step();
        check("single_idle_back", idle0, 1);

        // Fairness, also watching the depth-1 instance pace itself.
        clr = 1'b1;
        step();
        clr = 1'b0;
        all_valid();
        for (int i = 0; i < 12; i++) begin
            step();
            check("fair_grant", last_grant, i % 4);
            check("d1_grant", rdy1, (i % 2 == 0) ? (1 << ((i / 2) % 4)) : 0);
            if (i >= 2) check("fair_res_id", rid0, (i - 2) % 4);
            refill(1);
        end

        // Backpressure, then release.
        rr = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_grant >= 0) grants++;
            refill(1);
        end
        check("bp_grant_count", grants, 2);
        check("bp_stalled", rdy0, 0);
        rr = 1'b1;
        step();
        check("bp_resume_same_cycle", last_grant >= 0, 1);
        refill(1);
        for (int i = 0; i < 8; i++) begin
            step();
            refill(1);
        end

        // Flush with one buffered and one in flight.
        rr = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        refill(1);
        step();
        refill(1);
        clr = 1'b1;
        step();
        check("flush_corr_clear", cclr0, 1);
        clr = 1'b0;
        rr = 1'b1;
        step();
        check("flush_res_valid", rv0, 0);
        check("flush_idle", idle0, 1);
        check("flush_next_grant", last_grant, 0);
        refill(1);

        // Asynchronous reset in the middle of streaming.
        for (int i = 0; i < 5; i++) begin
            step();
            refill(1);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("async");
        exp_q.delete();
        g_last = N - 1;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();
        check("async_first_grant", last_grant, 0);
        refill(1);
        step();
        refill(1);
        step();
        check("async_first_valid", rv0, 1);
        check("async_first_id", rid0, 0);
        refill(1);

        // Randomized traffic with backpressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            rr  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 49) == 0);
            step();
            refill(2);
        end
        clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/expu_correction_arbiter.md
# expu_correction_arbiter

Round-robin arbiter and sequencer that shares one mantissa correction unit between `N_REQ` requesters. It accepts mantissas over per-requester valid/ready handshakes and drives the correction unit's `enable_i`, `clear_i` and `mantissa_i`. It tracks the unit's single register stage and collects `corrected_mantissa_o` into a result FIFO. The FIFO is tagged with requester ID and emits results in issue order under downstream backpressure.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `INPUT_FRACTION`, default 7: mantissa width; must equal the correction unit's `INPUT_FRACTION`.
- `FIFO_DEPTH`, default 2: result FIFO entries; must be ≥ 1. Values ≥ 2 give one result per cycle.
- `ID_WIDTH`, localparam: `$clog2(N_REQ)`.
- `clk_i` input 1: the single clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `clear_i` input 1: synchronous flush.
- `req_valid_i` input `N_REQ`: request valid, one bit per requester.
- `req_mant_i` input `N_REQ*INPUT_FRACTION`: mantissas. Requester k occupies bits `[k*INPUT_FRACTION +: INPUT_FRACTION]`.
- `req_ready_o` output `N_REQ`: one-hot grant, or all zero.
- `corr_enable_o` output 1: drives the correction unit's `enable_i`.
- `corr_clear_o` output 1: drives the correction unit's `clear_i`.
- `corr_mantissa_o` output `INPUT_FRACTION`: drives the correction unit's `mantissa_i`.
- `corr_result_i` input `INPUT_FRACTION`: from the correction unit's `corrected_mantissa_o`.
- `res_valid_o` output 1: result FIFO not empty.
- `res_ready_i` input 1: downstream accepts the result.
- `res_mant_o` output `INPUT_FRACTION`: head corrected mantissa.
- `res_id_o` output `ID_WIDTH`: requester index of the head result.
- `idle_o` output 1: nothing in flight and FIFO empty.

## Operation
- **Issue condition.** Let `pop = res_valid_o & res_ready_i` and `inflight = slot_valid_q`. Issue is allowed when `count + inflight - pop < FIFO_DEPTH` and `clear_i` is low.
- **Arbitration.** Round-robin with a pointer `last_q`. Search order is `last_q+1, last_q+2, …` modulo `N_REQ`. The first requester with valid high is granted.
  - Grant is combinational: `req_ready_o[k] = issue_ok & winner==k`.
  - Grant never depends on `req_ready_o` feedback.
- **On grant (handshake = valid & ready):**
  - `corr_enable_o = 1` and `corr_mantissa_o = req_mant_i[winner]`.
  - `last_q <= winner`, `slot_valid_q <= 1`, `slot_id_q <= winner`.
- **No grant:** `corr_enable_o = 0`, `corr_mantissa_o = 0`, `slot_valid_q <= 0`.
- **Capture.** When `slot_valid_q` is high, `corr_result_i` is valid in that same cycle (the correction unit is combinational after its register). It is pushed with `slot_id_q` into the FIFO at the next edge.
- **FIFO.**
  - Circular buffer with write/read pointers wrapping at `FIFO_DEPTH`, plus `count` of width `$clog2(FIFO_DEPTH+1)`.
  - Push and pop may occur in the same cycle. This is legal when full because the issue condition guarantees no overflow; `count` is unchanged in that case.
  - Pop when empty is ignored.
- **Ordering.** Results leave in grant order. IDs match the granted requester.
- **`corr_clear_o`** equals `clear_i` (combinational).
- **`clear_i` high:**
  - No grant and `corr_enable_o = 0`.
  - At the next edge: `slot_valid_q`, FIFO pointers and `count` go to 0, and `last_q` goes to `N_REQ-1`.
  - The in-flight result is discarded. `clear_i` has priority over push and pop.
- **`idle_o`** = `~slot_valid_q & (count == 0)`.
- **Assertions.**
  - Overflow: push while full without a simultaneous pop.
  - `req_ready_o` is not one-hot0.

## Timing
- **Reset values (asynchronous, `rst_ni` low):**
  - `slot_valid_q=0`, `slot_id_q=0`, `last_q=N_REQ-1` (requester 0 has first priority), FIFO empty.
  - Hence `res_valid_o=0`, `res_mant_o=0`, `res_id_o=0`, `idle_o=1`, `req_ready_o=0`, `corr_enable_o=0`, `corr_clear_o=clear_i`, `corr_mantissa_o=0`.
  - FIFO storage is reset to 0.
- **Latency.** A handshake in cycle T makes `res_valid_o` high in cycle T+2 with that result at the head, provided the FIFO was empty.
- **Throughput.**
  - `FIFO_DEPTH ≥ 2` with `res_ready_i` held high: one grant per cycle.
  - `FIFO_DEPTH = 1`: at most one grant every 2 cycles.
- **Backpressure.** With `res_ready_i=0`, grants stop once `count + inflight == FIFO_DEPTH`. The first grant resumes in the same cycle that `res_ready_i` pops.
- **Reset mid-operation.** Everything returns to reset values immediately. In-flight and buffered results are lost, and nothing is emitted after reset release until a new grant.
- **`clear_i` for one cycle.** `res_valid_o` is low from the cycle after the clear edge. Grants may resume in the following cycle.
- **Requester hold.** A requester must keep `req_valid_i` and its mantissa stable until granted. The arbiter stores nothing before the grant.

## Test plan
- **Single request:** after reset, requester 2 presents `7'h40` for one grant with `res_ready_i=1` → grant at T, `corr_enable_o=1` at T, `res_valid_o` at T+2 carrying `res_id_o=2` and `res_mant_o` equal to the golden corrected value of `7'h40`; `idle_o` returns to 1 at T+3.
- **Fairness:** all 4 requesters valid continuously with `res_ready_i=1` → grant sequence 0,1,2,3,0,1… one per cycle; output IDs follow the same sequence starting at cycle 2.
- **Backpressure:** `FIFO_DEPTH=2`, `res_ready_i=0`, all requesters valid → exactly 2 grants and then `req_ready_o=0`; raise `res_ready_i` → one pop per cycle and grants resume in the same cycle; no loss or reordering.
- **Flush:** `clear_i` pulsed while one result is in flight and one is buffered → `corr_clear_o=1` that cycle; next cycle `res_valid_o=0` and `idle_o=1`; the next grant goes to requester 0.
- **`FIFO_DEPTH=1`:** continuous requests with `res_ready_i=1` → one grant every other cycle; no overflow assertion fires.
- **Async reset:** `rst_ni` asserted between clock edges during streaming → all outputs at reset values immediately; after release, the first result has `res_id_o=0` when requester 0 is valid.
